pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state changes on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: load_use_hazard  in  1  load-use stall request from the hazard detection unit.
REQ-004 SHALL have ports: branch_taken_ex  in  1  taken branch or jump redirect resolved in EX.
REQ-005 SHALL have ports: div_req_ex  in  1  EX holds a DIV/DIVU/REM/REMU instruction.
REQ-006 SHALL have ports: div_done  in  1  single-cycle pulse from the iterative divider when its result is valid.
REQ-007 SHALL have ports: mem_busy  in  1  data memory wait; the whole pipeline freezes.
REQ-008 SHALL have ports: pc_write_en, if_id_write_en, id_ex_write_en, ex_ma_write_en, ma_wb_write_en  out  1 each  stage register enables.
REQ-009 SHALL have ports: if_id_flush, id_ex_flush, ex_ma_flush  out  1 each  bubble insertion (NOP) into that register.
REQ-010 SHALL have ports: div_start  out  1  one-cycle start pulse to the divider.
REQ-011 SHALL have ports: div_timeout  out  1  sticky error flag.
REQ-012 SHALL have ports: stall_cycles  out  16  saturating count of cycles with pc_write_en=0.
REQ-013 SHALL have parameter DIV_TIMEOUT, default 63, meaning the maximum number of DIV_WAIT cycles before abort.

Function
REQ-014 SHALL implement states RUN and DIV_WAIT; the 6-bit wait counter and the done_pending flag are registered.
REQ-015 In RUN with no request, all enables SHALL be 1, all flushes 0, and div_start 0.
REQ-016 In RUN, priority SHALL be mem_busy > div_req_ex > branch_taken_ex > load_use_hazard.
REQ-017 When mem_busy=1 in any state, all enables SHALL be 0, all flushes 0, and div_start 0; state SHALL hold and the wait counter SHALL hold.
REQ-018 In RUN with div_req_ex=1, the block SHALL drive div_start=1 and hold pc, IF/ID, ID/EX and EX/MA (enables 0) while ma_wb_write_en=1 and ex_ma_flush=1; it SHALL clear the counter and go to DIV_WAIT next cycle.
REQ-019 In RUN with branch_taken_ex=1, the block SHALL keep all enables at 1 and set if_id_flush=1 and id_ex_flush=1; load_use_hazard SHALL be ignored that cycle.
REQ-020 In RUN with load_use_hazard=1 alone, the block SHALL drive pc_write_en=0, if_id_write_en=0 and id_ex_flush=1, with the remaining enables at 1.
REQ-021 In DIV_WAIT, pc, IF/ID, ID/EX and EX/MA SHALL be held, ex_ma_flush SHALL be 1, ma_wb_write_en SHALL be 1, and the counter SHALL increment by 1 per cycle.
REQ-022 In DIV_WAIT, when (div_done or done_pending) and not mem_busy, all enables SHALL be 1, all flushes 0, done_pending SHALL clear, and the next state SHALL be RUN.
REQ-023 When div_done=1 coincides with mem_busy=1, the block SHALL set done_pending and SHALL release on the first cycle mem_busy=0.
REQ-024 When the counter equals DIV_TIMEOUT without done, the block SHALL set div_timeout and go to RUN, that cycle using REQ-022 enables but with ex_ma_flush=1.
REQ-025 div_start SHALL be asserted only in the RUN->DIV_WAIT transition cycle, so that it never repeats for the same instruction.
REQ-026 div_done received in RUN SHALL be ignored.
REQ-027 stall_cycles SHALL increment when pc_write_en=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-028 When reset_n=0 on a clock edge, the block SHALL set state to RUN, counter to 0, done_pending to 0, div_timeout to 0 and stall_cycles to 0; it SHALL abort any divide in progress and drive no div_start.
REQ-029 During reset, outputs SHALL be the RUN idle values: enables 1, flushes 0, div_start 0.

Verification
REQ-030 Load-use: load_use_hazard=1 for 1 cycle -> pc_write_en=0, if_id_write_en=0, id_ex_flush=1 that cycle; stall_cycles = 1.
REQ-031 Branch plus hazard: branch_taken_ex=1 and load_use_hazard=1 together -> if_id_flush=1, id_ex_flush=1, all enables 1, stall_cycles unchanged.
REQ-032 Divide: div_req_ex=1 -> div_start pulses for 1 cycle; div_done is pulsed 33 cycles later -> release on that cycle; stall_cycles = 34.
REQ-033 Done under freeze: div_done coincides with mem_busy=1 for 3 cycles -> stay frozen, then release on the first mem_busy=0 cycle.
REQ-034 Timeout: no div_done -> after 63 DIV_WAIT cycles div_timeout=1 with ex_ma_flush=1, state RUN; div_timeout stays 1 until reset.
REQ-035 Reset mid-divide: reset_n=0 at DIV_WAIT cycle 10 -> next cycle is RUN idle outputs with counter 0; a late div_done is ignored.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Stall/flush sequencer for a 5-stage pipeline with an iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int unsigned DIV_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_use_hazard,
    input  logic        branch_taken_ex,
    input  logic        div_req_ex,
    input  logic        div_done,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_write_en,
    output logic        ex_ma_write_en,
    output logic        ma_wb_write_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_ma_flush,
    output logic        div_start,
    output logic        div_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] TIMEOUT_CNT = 6'(DIV_TIMEOUT);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_pending_q, done_pending_d;
    logic        div_timeout_q, div_timeout_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_write_en = 1'b1;
        ex_ma_write_en = 1'b1;
        ma_wb_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_ma_flush    = 1'b0;
        div_start      = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_pending_d = done_pending_q;
        div_timeout_d  = div_timeout_q;

        if (reset_n) begin
            if (mem_busy) begin
                // Full freeze; a completion arriving now is remembered for later.
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_write_en = 1'b0;
                ex_ma_write_en = 1'b0;
                ma_wb_write_en = 1'b0;
                if (state_q == DIV_WAIT && div_done)
                    done_pending_d = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (div_req_ex) begin
                            pc_write_en    = 1'b0;
                            if_id_write_en = 1'b0;
                            id_ex_write_en = 1'b0;
                            ex_ma_write_en = 1'b0;
                            ex_ma_flush    = 1'b1;
                            div_start      = 1'b1;
                            cnt_d          = 6'd0;
                            state_d        = DIV_WAIT;
                        end else if (branch_taken_ex) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use_hazard) begin
                            pc_write_en    = 1'b0;
                            if_id_write_en = 1'b0;
                            id_ex_flush    = 1'b1;
                        end
                    end
                    DIV_WAIT: begin
                        if (div_done || done_pending_q) begin
                            done_pending_d = 1'b0;
                            state_d        = RUN;
                        end else if (cnt_q == TIMEOUT_CNT) begin
                            // Abort: let the pipeline move but drop the divide result.
                            ex_ma_flush   = 1'b1;
                            div_timeout_d = 1'b1;
                            state_d       = RUN;
                        end else begin
                            pc_write_en    = 1'b0;
                            if_id_write_en = 1'b0;
                            id_ex_write_en = 1'b0;
                            ex_ma_write_en = 1'b0;
                            ex_ma_flush    = 1'b1;
                            cnt_d          = cnt_q + 6'd1;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_write_en && stall_cycles_q != 16'hFFFF)
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= RUN;
            cnt_q          <= 6'd0;
            done_pending_q <= 1'b0;
            div_timeout_q  <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            done_pending_q <= done_pending_d;
            div_timeout_q  <= div_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign div_timeout  = div_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed scoreboard bench for pipeline_stall_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        reset_n, load_use_hazard, branch_taken_ex, div_req_ex, div_done, mem_busy;
    logic        pc_write_en, if_id_write_en, id_ex_write_en, ex_ma_write_en, ma_wb_write_en;
    logic        if_id_flush, id_ex_flush, ex_ma_flush, div_start, div_timeout;
    logic [15:0] stall_cycles;

    pipeline_stall_controller #(.DIV_TIMEOUT(63)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load_use_hazard (load_use_hazard),
        .branch_taken_ex (branch_taken_ex),
        .div_req_ex      (div_req_ex),
        .div_done        (div_done),
        .mem_busy        (mem_busy),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .id_ex_write_en  (id_ex_write_en),
        .ex_ma_write_en  (ex_ma_write_en),
        .ma_wb_write_en  (ma_wb_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_ma_flush     (ex_ma_flush),
        .div_start       (div_start),
        .div_timeout     (div_timeout),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // ctl = {pc, if_id, id_ex, ex_ma, ma_wb enables, if_id/id_ex/ex_ma flushes, div_start}
    localparam logic [8:0] IDLE   = 9'b11111_000_0;
    localparam logic [8:0] FREEZE = 9'b00000_000_0;
    localparam logic [8:0] DIVST  = 9'b00001_001_1;
    localparam logic [8:0] DIVW   = 9'b00001_001_0;
    localparam logic [8:0] BR     = 9'b11111_110_0;
    localparam logic [8:0] LU     = 9'b00111_010_0;
    localparam logic [8:0] TOUT   = 9'b11111_001_0;

    typedef struct packed {
        logic [8:0]  ctl;
        logic        to;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;
    logic [15:0] exp_sc = 16'd0;

    task automatic step(input logic rn, input logic lu, input logic br, input logic dr,
                        input logic dd, input logic mb, input logic [8:0] ctl, input logic to);
        exp_t       e;
        logic [8:0] obs;
        @(posedge clk);
        #1;
        reset_n = rn; load_use_hazard = lu; branch_taken_ex = br;
        div_req_ex = dr; div_done = dd; mem_busy = mb;
        // Registered counters seen this cycle reflect history up to the previous edge.
        sb.push_back('{ctl: ctl, to: to, sc: exp_sc});
        if (!rn)
            exp_sc = 16'd0;
        else if (!ctl[8] && exp_sc != 16'hFFFF)
            exp_sc = exp_sc + 16'd1;
        @(negedge clk);
        step_no++;
        e   = sb.pop_front();
        obs = {pc_write_en, if_id_write_en, id_ex_write_en, ex_ma_write_en, ma_wb_write_en,
               if_id_flush, id_ex_flush, ex_ma_flush, div_start};
        checks++;
        assert (obs === e.ctl) else begin
            failures++;
            $error("FAIL ctl step=%0d observed=%b expected=%b", step_no, obs, e.ctl);
        end
        checks++;
        assert (div_timeout === e.to) else begin
            failures++;
            $error("FAIL div_timeout step=%0d observed=%b expected=%b", step_no, div_timeout, e.to);
        end
        checks++;
        assert (stall_cycles === e.sc) else begin
            failures++;
            $error("FAIL stall_cycles step=%0d observed=%0d expected=%0d", step_no, stall_cycles, e.sc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; load_use_hazard = 1'b0; branch_taken_ex = 1'b0;
        div_req_ex = 1'b0; div_done = 1'b0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values, with requests present that must be ignored while in reset
        step(0, 1, 0, 1, 0, 0, IDLE, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // Load-use, branch overriding hazard, branch alone
        step(1, 1, 0, 0, 0, 0, LU,   0);
        step(1, 1, 1, 0, 0, 0, BR,   0);
        step(1, 0, 1, 0, 0, 0, BR,   0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // mem_busy outranks everything; div_req outranks branch
        step(1, 1, 1, 1, 0, 1, FREEZE, 0);
        step(1, 0, 1, 1, 0, 0, DIVST, 0);
        for (int i = 0; i < 33; i++)
            step(1, 0, 0, 1, 0, 0, DIVW, 0);
        step(1, 0, 0, 1, 1, 0, IDLE, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // Completion arriving during a freeze releases on the first free cycle
        step(1, 0, 0, 1, 0, 0, DIVST, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 1, 0, 0, DIVW, 0);
        step(1, 0, 0, 1, 1, 1, FREEZE, 0);
        step(1, 0, 0, 1, 0, 1, FREEZE, 0);
        step(1, 0, 0, 1, 0, 1, FREEZE, 0);
        step(1, 0, 0, 1, 0, 0, IDLE, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // div_done in RUN has no effect
        step(1, 0, 0, 0, 1, 0, IDLE, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // Reset in the middle of a divide
        step(1, 0, 0, 1, 0, 0, DIVST, 0);
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 1, 0, 0, DIVW, 0);
        step(0, 0, 0, 1, 0, 0, IDLE, 0);
        step(1, 0, 0, 0, 1, 0, IDLE, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        // Timeout: 63 wait cycles (counter frozen by one mem_busy cycle), then abort
        step(1, 0, 0, 1, 0, 0, DIVST, 0);
        for (int i = 0; i < 30; i++)
            step(1, 0, 0, 1, 0, 0, DIVW, 0);
        step(1, 0, 0, 1, 0, 1, FREEZE, 0);
        for (int i = 0; i < 33; i++)
            step(1, 0, 0, 1, 0, 0, DIVW, 0);
        step(1, 0, 0, 1, 0, 0, TOUT, 0);
        step(1, 0, 0, 0, 0, 0, IDLE, 1);
        step(1, 1, 0, 0, 0, 0, LU,   1);
        step(1, 0, 0, 0, 1, 0, IDLE, 1);

        // Sticky flag and counter clear only on reset
        step(0, 0, 0, 0, 0, 0, IDLE, 1);
        step(1, 0, 0, 0, 0, 0, IDLE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
